// File: rtl/rs_gf16_pkg.sv
// Shared GF(16) definitions for the RS(15,9) link: field constants, power table,
// generic multiplier and the receive front-end state type.
package rs_gf16_pkg;

    localparam int unsigned N     = 15;
    localparam int unsigned K     = 9;
    localparam int unsigned SYM_W = 4;
    localparam int unsigned NSYN  = N - K;

    localparam logic [SYM_W:0] PRIM_POLY = 5'b10011;

    localparam logic [SYM_W-1:0] ALPHA_POW [0:14] = '{
        4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'hB,
        4'h5, 4'hA, 4'h7, 4'hE, 4'hF, 4'hD, 4'h9
    };

    typedef enum logic [1:0] {
        COLLECT,
        ISSUE,
        WAIT
    } rxState_t;

    // Shift-and-add multiply; with a constant operand it folds to a small XOR network.
    function automatic logic [SYM_W-1:0] gf_mul(input logic [SYM_W-1:0] a,
                                                input logic [SYM_W-1:0] b);
        logic [SYM_W-1:0] prod;
        logic [SYM_W-1:0] aa;
        prod = '0;
        aa   = a;
        for (int unsigned i = 0; i < SYM_W; i++) begin
            if (b[i]) prod = prod ^ aa;
            aa = aa[SYM_W-1] ? ({aa[SYM_W-2:0], 1'b0} ^ PRIM_POLY[SYM_W-1:0])
                             : {aa[SYM_W-2:0], 1'b0};
        end
        return prod;
    endfunction

endpackage

// File: rtl/rs_syndrome_cell.sv
// One Horner accumulator for syndrome S_POW. acc presents the value including the
// current symbol so the parent can capture a frame's final syndrome on its last edge.
module rs_syndrome_cell
    import rs_gf16_pkg::*;
#(
    parameter int unsigned POW = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             first,
    input  logic [SYM_W-1:0] r,
    output logic [SYM_W-1:0] acc
);

    logic [SYM_W-1:0] accQ;

    assign acc = first ? r : (gf_mul(accQ, ALPHA_POW[POW]) ^ r);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            accQ <= '0;
        end else if (en) begin
            accQ <= acc;
        end
    end

endmodule

// File: rtl/rs_rx_syndrome_front.sv
// RS(15,9) receive front end: assembles a 15-symbol frame, computes S1..S6 on the fly
// and hands the word to the toggle-started decoder, respecting its busy flag.
module rs_rx_syndrome_front
    import rs_gf16_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [SYM_W-1:0]      sym_in,
    input  logic                  sym_valid,
    input  logic                  sym_sof,
    output logic                  sym_ready,
    input  logic                  decoder_busy,
    output logic [N*SYM_W-1:0]    word_out,
    output logic                  decode_toggle,
    output logic [NSYN*SYM_W-1:0] syndromes,
    output logic                  err_detected,
    output logic                  sync_err,
    output logic [15:0]           frames_ok,
    output logic [15:0]           frames_err
);

    localparam logic [3:0] LAST_COUNT = 4'(N - 1);

    rxState_t                  state;
    logic [3:0]                count;
    logic [(N-1)*SYM_W-1:0]    wordSr;
    logic [NSYN*SYM_W-1:0]     synNext;
    logic                      accept;
    logic                      take;

    assign accept = sym_valid & sym_ready;
    // A symbol with no frame open and no sof is dropped and must not touch the accumulators.
    assign take   = accept & ((count != '0) | sym_sof);

    for (genvar j = 1; j <= NSYN; j++) begin : gSyn
        rs_syndrome_cell #(.POW(j)) uCell (
            .clk   (clk),
            .rst   (rst),
            .en    (take),
            .first (sym_sof),
            .r     (sym_in),
            .acc   (synNext[SYM_W*(j-1) +: SYM_W])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= COLLECT;
            count         <= '0;
            wordSr        <= '0;
            sym_ready     <= 1'b0;
            word_out      <= '0;
            decode_toggle <= 1'b0;
            syndromes     <= '0;
            err_detected  <= 1'b0;
            sync_err      <= 1'b0;
            frames_ok     <= '0;
            frames_err    <= '0;
        end else begin
            sync_err <= 1'b0;
            case (state)
                COLLECT: begin
                    sym_ready <= 1'b1;
                    if (accept) begin
                        if (!take) begin
                            sync_err <= 1'b1;
                        end else begin
                            wordSr <= {wordSr[(N-2)*SYM_W-1:0], sym_in};
                            if (sym_sof) begin
                                if (count != '0) sync_err <= 1'b1;
                                count <= 4'd1;
                            end else if (count == LAST_COUNT) begin
                                word_out     <= {wordSr, sym_in};
                                syndromes    <= synNext;
                                err_detected <= |synNext;
                                if (|synNext) begin
                                    if (frames_err != '1) frames_err <= frames_err + 16'd1;
                                end else begin
                                    if (frames_ok != '1) frames_ok <= frames_ok + 16'd1;
                                end
                                count     <= '0;
                                sym_ready <= 1'b0;
                                state     <= ISSUE;
                            end else begin
                                count <= count + 4'd1;
                            end
                        end
                    end
                end
                ISSUE, WAIT: begin
                    if (!decoder_busy) begin
                        decode_toggle <= ~decode_toggle;
                        sym_ready     <= 1'b1;
                        state         <= COLLECT;
                    end else begin
                        state <= WAIT;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_rs_rx_syndrome_front.sv
// Directed bench for rs_rx_syndrome_front: table of frames with hand-computed
// syndromes, plus framing, backpressure and reset sequences.
module tb_rs_rx_syndrome_front;

    logic        clk;
    logic        rst;
    logic [3:0]  sym_in;
    logic        sym_valid;
    logic        sym_sof;
    logic        sym_ready;
    logic        decoder_busy;
    logic [59:0] word_out;
    logic        decode_toggle;
    logic [23:0] syndromes;
    logic        err_detected;
    logic        sync_err;
    logic [15:0] frames_ok;
    logic [15:0] frames_err;

    rs_rx_syndrome_front dut (
        .clk          (clk),
        .rst          (rst),
        .sym_in       (sym_in),
        .sym_valid    (sym_valid),
        .sym_sof      (sym_sof),
        .sym_ready    (sym_ready),
        .decoder_busy (decoder_busy),
        .word_out     (word_out),
        .decode_toggle(decode_toggle),
        .syndromes    (syndromes),
        .err_detected (err_detected),
        .sync_err     (sync_err),
        .frames_ok    (frames_ok),
        .frames_err   (frames_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [59:0] word;
        logic [23:0] syn;
        logic        err;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    logic expToggle = 1'b0;
    int   expOk = 0;
    int   expErr = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sendSym(input logic [3:0] s, input logic sof);
        int unsigned waitCnt;
        waitCnt = 0;
        @(negedge clk);
        while (!sym_ready && waitCnt < 50) begin
            @(negedge clk);
            waitCnt++;
        end
        if (!sym_ready) check("sym_ready_timeout", 64'(sym_ready), 64'd1);
        sym_in    = s;
        sym_valid = 1'b1;
        sym_sof   = sof;
        @(posedge clk);
        #1;
        sym_valid = 1'b0;
        sym_sof   = 1'b0;
    endtask

    // Sends a full frame; busyCycles > 0 holds decoder_busy through the hand-off.
    task automatic runFrame(input vec_t v, input logic expSync, input int busyCycles);
        decoder_busy = (busyCycles > 0);
        sendSym(v.word[59:56], 1'b1);
        check({v.name, "_sof_sync"}, 64'(sync_err), 64'(expSync));
        for (int i = 13; i >= 0; i--) sendSym(v.word[4*i +: 4], 1'b0);
        if (v.err) expErr++; else expOk++;
        check({v.name, "_word"}, 64'(word_out), 64'(v.word));
        check({v.name, "_syn"}, 64'(syndromes), 64'(v.syn));
        check({v.name, "_err"}, 64'(err_detected), 64'(v.err));
        check({v.name, "_ok_cnt"}, 64'(frames_ok), 64'(expOk));
        check({v.name, "_err_cnt"}, 64'(frames_err), 64'(expErr));
        check({v.name, "_ready_low"}, 64'(sym_ready), 64'd0);
        for (int c = 0; c < busyCycles; c++) begin
            @(posedge clk);
            #1;
            check({v.name, "_busy_ready"}, 64'(sym_ready), 64'd0);
            check({v.name, "_busy_toggle"}, 64'(decode_toggle), 64'(expToggle));
        end
        decoder_busy = 1'b0;
        @(posedge clk);
        #1;
        expToggle = ~expToggle;
        check({v.name, "_toggle"}, 64'(decode_toggle), 64'(expToggle));
        check({v.name, "_ready_back"}, 64'(sym_ready), 64'd1);
    endtask

    task automatic checkAllZero(input string name);
        check({name, "_word"}, 64'(word_out), 64'd0);
        check({name, "_syn"}, 64'(syndromes), 64'd0);
        check({name, "_err"}, 64'(err_detected), 64'd0);
        check({name, "_toggle"}, 64'(decode_toggle), 64'd0);
        check({name, "_sync"}, 64'(sync_err), 64'd0);
        check({name, "_ready"}, 64'(sym_ready), 64'd0);
        check({name, "_frames"}, 64'({frames_ok, frames_err}), 64'd0);
    endtask

    vec_t vecs[5];
    vec_t zeroVec;

    initial begin
        vecs[0] = '{"zero",    60'h0,                24'h000000, 1'b0};
        vecs[1] = '{"err_x1",  60'h10,               24'hC63842, 1'b1};
        vecs[2] = '{"err_x0",  60'h1,                24'h111111, 1'b1};
        vecs[3] = '{"err_x14", 60'h100000000000000,  24'hA7EFD9, 1'b1};
        vecs[4] = '{"err_x2_5",60'h500,              24'h6829F7, 1'b1};
        zeroVec = vecs[0];

        rst = 1'b1;
        sym_in = '0;
        sym_valid = 1'b0;
        sym_sof = 1'b0;
        decoder_busy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkAllZero("reset");
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) runFrame(vecs[i], 1'b0, 0);

        // Symbol without sof while idle is dropped.
        sendSym(4'h5, 1'b0);
        check("drop_sync", 64'(sync_err), 64'd1);
        check("drop_frames", 64'({frames_ok, frames_err}), 64'({16'(expOk), 16'(expErr)}));
        @(posedge clk);
        #1;
        check("drop_sync_pulse", 64'(sync_err), 64'd0);

        // Abandoned partial frame: sof after 7 symbols restarts cleanly.
        sendSym(4'hF, 1'b1);
        for (int i = 0; i < 6; i++) sendSym(4'hF, 1'b0);
        runFrame(vecs[1], 1'b1, 0);

        runFrame(zeroVec, 1'b0, 5);

        // Reset mid-frame: everything cleared, no toggle.
        sendSym(4'h7, 1'b1);
        for (int i = 0; i < 6; i++) sendSym(4'h3, 1'b0);
        rst = 1'b1;
        #1;
        checkAllZero("midreset");
        @(negedge clk);
        rst = 1'b0;
        expToggle = 1'b0;
        expOk = 0;
        expErr = 0;
        runFrame(zeroVec, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
